// File: rtl/uart_tx_scheduler_if.sv
// Requester-side bundle and UART TX outputs of the scheduler.
// master = client/bench side, slave = scheduler side.
interface uart_tx_scheduler_if #(
  parameter int WORD_LENGTH = 8,
  parameter int NUM_REQ     = 4
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*WORD_LENGTH-1:0] req_data;
  logic [NUM_REQ-1:0]             grant;
  logic [WORD_LENGTH-1:0]         DATATX;
  logic                           Transmit;
  logic                           busy;
  logic [1:0]                     active_id;

  modport master (
    output req, req_data,
    input  grant, DATATX, Transmit, busy, active_id
  );

  modport slave (
    input  req, req_data,
    output grant, DATATX, Transmit, busy, active_id
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter; it owns frame
// timing because the UART exposes no TX-busy indication.
module uart_tx_scheduler #(
  parameter int WORD_LENGTH = 8,
  parameter int NUM_REQ     = 4,
  parameter int BIT_CYCLES  = 16,
  parameter int FRAME_BITS  = 11,
  parameter int GAP_CYCLES  = 2
) (
  input logic                clk,
  input logic                reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int FRAME = FRAME_BITS * BIT_CYCLES;
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT, GAP
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [1:0]             last;
  logic [1:0]             win;
  logic                   hit;
  logic [NUM_REQ-1:0]     rq;
  logic [WORD_LENGTH-1:0] sel;
  int                     idx;

  always_comb begin
    win = last;
    hit = 1'b0;
    rq  = '0;
    idx = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      rq  = bus.req >> idx;
      if (!hit && rq[0]) begin
        win = 2'(idx);
        hit = 1'b1;
      end
    end
    sel = WORD_LENGTH'(bus.req_data >>
          (int'(win) * WORD_LENGTH));
  end

  // SEND is the strobe cycle and also the first cycle of the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last          <= 2'(NUM_REQ - 1);
      cnt           <= '0;
      bus.grant     <= '0;
      bus.DATATX    <= '0;
      bus.Transmit  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.active_id <= '0;
    end else begin
      bus.grant    <= '0;
      bus.Transmit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            bus.grant     <= NUM_REQ'(1) << win;
            bus.DATATX    <= sel;
            bus.active_id <= win;
            last          <= win;
            bus.busy      <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          bus.Transmit <= 1'b1;
          cnt          <= CW'(FRAME - 1);
          state        <= SEND;
        end
        SEND, WAIT: begin
          state <= WAIT;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (GAP_CYCLES > 0) begin
            cnt   <= CW'(GAP_CYCLES - 1);
            state <= GAP;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: default build and a GAP_CYCLES=0 build
// checked every cycle against an event-time reference model.
module tb_uart_tx_scheduler;
  localparam int F = 176;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.WORD_LENGTH(8), .NUM_REQ(4)) bus ();
  uart_tx_scheduler_if #(.WORD_LENGTH(8), .NUM_REQ(4)) bus0 ();

  uart_tx_scheduler #(
    .WORD_LENGTH(8), .NUM_REQ(4), .BIT_CYCLES(16),
    .FRAME_BITS(11), .GAP_CYCLES(2)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  uart_tx_scheduler #(
    .WORD_LENGTH(8), .NUM_REQ(4), .BIT_CYCLES(16),
    .FRAME_BITS(11), .GAP_CYCLES(0)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int gapc    [2] = '{2, 0};
  int per_exp [2] = '{180, 178};

  logic [3:0] req_v [2];
  logic [7:0] d     [2][4];

  // model: grant edge g -> strobe at g+1, idle again after g+F+G+1
  int         m_last  [2];
  int         t_idle  [2];
  int         m_act   [2];
  int         tx_edge [2];
  int         prev_tx [2];
  bit         per_on  [2];
  logic [3:0] g_hot   [2];
  logic [7:0] m_data  [2];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input int u);
    int  w;
    bit  hit;
    w        = 0;
    hit      = 1'b0;
    g_hot[u] = '0;
    if (reset) begin
      m_last[u]  = 3;
      t_idle[u]  = cyc;
      m_data[u]  = '0;
      m_act[u]   = 0;
      tx_edge[u] = -1;
      prev_tx[u] = -1;
    end else if (cyc > t_idle[u] && req_v[u] != '0) begin
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_last[u] + k) % 4;
        if (!hit && ((req_v[u] >> j) & 4'd1) != 4'd0) begin
          hit = 1'b1;
          w   = j;
        end
      end
      g_hot[u]   = 4'd1 << w;
      m_data[u]  = d[u][w];
      m_act[u]   = w;
      m_last[u]  = w;
      tx_edge[u] = cyc + 1;
      t_idle[u]  = cyc + F + gapc[u] + 1;
    end
  endtask

  task automatic check_all(input int u,
                           input logic [3:0] gr,
                           input logic [7:0] dt,
                           input logic tx,
                           input logic bz,
                           input logic [1:0] act);
    string s;
    s = $sformatf("u%0d@%0d", u, cyc);
    chk({s, " grant"}, 32'(gr), 32'(g_hot[u]));
    chk({s, " DATATX"}, 32'(dt), 32'(m_data[u]));
    chk({s, " Transmit"}, 32'(tx),
        32'(cyc == tx_edge[u]));
    chk({s, " busy"}, 32'(bz), 32'(cyc < t_idle[u]));
    chk({s, " active_id"}, 32'(act), 32'(m_act[u]));
    if (tx === 1'b1) begin
      if (per_on[u] && prev_tx[u] >= 0)
        chk({s, " period"}, 32'(cyc - prev_tx[u]),
            32'(per_exp[u]));
      prev_tx[u] = cyc;
    end
  endtask

  task automatic tick();
    bus.req       = req_v[0];
    bus.req_data  = {d[0][3], d[0][2], d[0][1], d[0][0]};
    bus0.req      = req_v[1];
    bus0.req_data = {d[1][3], d[1][2], d[1][1], d[1][0]};
    @(posedge clk);
    cyc++;
    model(0);
    model(1);
    #1;
    check_all(0, bus.grant, bus.DATATX, bus.Transmit,
              bus.busy, bus.active_id);
    check_all(1, bus0.grant, bus0.DATATX, bus0.Transmit,
              bus0.busy, bus0.active_id);
    if (g_hot[1] != '0) d[1][0] = 8'($urandom);
  endtask

  task automatic wait_grant(input string tag,
                            input logic [3:0] exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (g_hot[0] == '0 && n < 400);
    chk(tag, 32'(bus.grant), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (cyc <= t_idle[0] && n < 400) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    req_v[0] = 4'hF;
    req_v[1] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      d[0][i] = 8'h10 + 8'(i);
      d[1][i] = 8'h00;
    end
    d[1][0]    = 8'h5A;
    prev_tx    = '{-1, -1};
    per_on     = '{1'b0, 1'b1};
    t_idle     = '{0, 0};
    tx_edge    = '{-1, -1};

    reset = 1'b1;
    tick();
    tick();
    chk("rst grant", 32'(bus.grant), 32'd0);
    chk("rst DATATX", 32'(bus.DATATX), 32'd0);
    chk("rst Transmit", 32'(bus.Transmit), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst active_id", 32'(bus.active_id), 32'd0);

    reset     = 1'b0;
    per_on[0] = 1'b1;
    wait_grant("rr0", 4'b0001);
    chk("rr0 data", 32'(bus.DATATX), 32'h10);
    wait_grant("rr1", 4'b0010);
    chk("rr1 data", 32'(bus.DATATX), 32'h11);
    wait_grant("rr2", 4'b0100);
    chk("rr2 data", 32'(bus.DATATX), 32'h12);
    wait_grant("rr3", 4'b1000);
    chk("rr3 data", 32'(bus.DATATX), 32'h13);
    wait_grant("rr4", 4'b0001);
    chk("rr4 data", 32'(bus.DATATX), 32'h10);
    req_v[0] = 4'b0000;
    wait_idle("contention idle");
    per_on[0] = 1'b0;

    req_v[0] = 4'b0100;
    d[0][2]  = 8'h07;
    wait_grant("single", 4'b0100);
    chk("single data", 32'(bus.DATATX), 32'h07);
    chk("single id", 32'(bus.active_id), 32'd2);
    req_v[0] = 4'b0000;
    tick();
    chk("single strobe", 32'(bus.Transmit), 32'd1);
    tick();
    chk("single strobe end", 32'(bus.Transmit), 32'd0);
    wait_idle("single idle");

    req_v[0] = 4'b1000;
    d[0][3]  = 8'hA3;
    wait_grant("late3", 4'b1000);
    req_v[0] = 4'b0000;
    repeat (20) tick();
    req_v[0] = 4'b0011;
    d[0][0]  = 8'hB0;
    d[0][1]  = 8'hB1;
    repeat (5) tick();
    chk("late held", 32'(bus.grant), 32'd0);
    wait_grant("wrap0", 4'b0001);
    chk("wrap0 data", 32'(bus.DATATX), 32'hB0);
    req_v[0] = 4'b0010;
    wait_grant("wrap1", 4'b0010);
    chk("wrap1 data", 32'(bus.DATATX), 32'hB1);
    req_v[0] = 4'b0000;
    wait_idle("wrap idle");

    req_v[0] = 4'b0100;
    d[0][2]  = 8'h33;
    wait_grant("mr2", 4'b0100);
    req_v[0] = 4'b0010;
    d[0][1]  = 8'h61;
    repeat (50) tick();
    reset = 1'b1;
    tick();
    chk("mr busy", 32'(bus.busy), 32'd0);
    chk("mr DATATX", 32'(bus.DATATX), 32'd0);
    reset = 1'b0;
    tick();
    chk("mr regrant", 32'(bus.grant), 32'b0010);
    chk("mr data", 32'(bus.DATATX), 32'h61);
    req_v[0] = 4'b0000;
    wait_idle("mr idle");

    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_v[0][2'(i)] && $urandom_range(0, 15) == 0)
        begin
          req_v[0][2'(i)] = 1'b1;
          d[0][i]         = 8'($urandom);
        end else if (req_v[0][2'(i)] &&
                     $urandom_range(0, 127) == 0) begin
          req_v[0][2'(i)] = 1'b0;
        end
      end
      reset = ($urandom_range(0, 2499) == 0);
      tick();
      for (int i = 0; i < 4; i++) begin
        if (g_hot[0][2'(i)]) begin
          if ($urandom_range(0, 1) == 1)
            req_v[0][2'(i)] = 1'b0;
          else
            d[0][i] = 8'($urandom);
        end
      end
    end
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
